// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
// The lead_zero_mask helper is only referenced when LEAD_ZERO_SUPPRESS_EN is defined.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned VALUE_W    = 32;

    localparam logic [NUM_DIGITS-1:0] DIGIT_ALL_OFF = 8'hFF;

    typedef enum logic [0:0] {
        SCAN_BLANK,
        SCAN_SHOW
    } scan_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bit k set when nibble k and every more-significant nibble are zero; digit 7 never set.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [VALUE_W-1:0] value);
        logic [NUM_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            all_zero = all_zero & (value[VALUE_W-1-4*k -: 4] == 4'h0);
            mask[k]  = all_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake and decoder-drive signals of the scan controller.
// master = requester/consumer side, slave = the controller itself.
interface seven_seg_scan_ctrl_if;
    import seven_seg_pkg::*;

    logic                  load_valid;
    logic [VALUE_W-1:0]    load_data;
    logic                  load_ready;
    logic [SEL_W-1:0]      sel;
    logic [VALUE_W-1:0]    disp_value;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_done;

    modport master (
        output load_valid, load_data,
        input  load_ready, sel, disp_value, digit_en, frame_done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sel, disp_value, digit_en, frame_done
    );

endinterface

// File: rtl/seven_seg_scan_ctrl_scan_phase_counter.sv
// Terminal-count counter shared by the SHOW and BLANK phases; the limit is
// selected by the caller and the count restarts whenever the phase changes.
module scan_phase_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == i_limit);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with blanking and frame-aligned value commit.
// Define LEAD_ZERO_SUPPRESS_EN to keep leading-zero digits dark during their SHOW slot.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_ctrl_if.slave bus
);

    localparam int unsigned      CNT_W      = $clog2(max_u(CLK_DIV, BLANK_CYCLES));
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t           r_state, w_state_d;
    logic [SEL_W-1:0]      r_sel, w_sel_d;
    logic [VALUE_W-1:0]    r_disp, w_disp_d;
    logic [VALUE_W-1:0]    r_buf, w_buf_d;
    logic                  r_pending, w_pending_d;
    logic                  r_load_ready;
    logic [NUM_DIGITS-1:0] r_digit_en, w_digit_en_d;
    logic                  r_frame_done, w_frame_done_d;
    logic                  w_phase_done;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_limit;

    assign w_limit  = (r_state == SCAN_SHOW) ? SHOW_LAST : BLANK_LAST;
    assign w_accept = bus.load_valid && r_load_ready;

    // Every terminal count is also a phase change, so done doubles as the clear.
    scan_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_phase_done),
        .i_limit (w_limit),
        .o_done  (w_phase_done)
    );

`ifdef LEAD_ZERO_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] w_lz_mask;
    assign w_lz_mask = lead_zero_mask(w_disp_d);
`endif

    always_comb begin
        w_state_d      = r_state;
        w_sel_d        = r_sel;
        w_disp_d       = r_disp;
        w_buf_d        = r_buf;
        w_pending_d    = r_pending;
        w_frame_done_d = 1'b0;
        w_digit_en_d   = DIGIT_ALL_OFF;

        case (r_state)
            SCAN_SHOW: begin
                if (w_phase_done) w_state_d = SCAN_BLANK;
            end
            SCAN_BLANK: begin
                if (w_phase_done) begin
                    w_state_d = SCAN_SHOW;
                    w_sel_d   = r_sel + 1'b1;
                    if (r_sel == SEL_W'(NUM_DIGITS - 1)) begin
                        w_frame_done_d = 1'b1;
                        if (r_pending) begin
                            w_disp_d    = r_buf;
                            w_pending_d = 1'b0;
                        end
                    end
                end
            end
        endcase

        // Accept needs pending clear, so it never collides with a commit.
        if (w_accept) begin
            w_buf_d     = bus.load_data;
            w_pending_d = 1'b1;
        end

        // Enables follow next-cycle sel/disp so all outputs change on the same edge.
        if (w_state_d == SCAN_SHOW) begin
            w_digit_en_d = ~(NUM_DIGITS'(1) << w_sel_d);
`ifdef LEAD_ZERO_SUPPRESS_EN
            if (w_lz_mask[w_sel_d]) w_digit_en_d = DIGIT_ALL_OFF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SCAN_BLANK;
            r_sel        <= '0;
            r_disp       <= '0;
            r_buf        <= '0;
            r_pending    <= 1'b0;
            r_load_ready <= 1'b1;
            r_digit_en   <= DIGIT_ALL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_sel        <= w_sel_d;
            r_disp       <= w_disp_d;
            r_buf        <= w_buf_d;
            r_pending    <= w_pending_d;
            r_load_ready <= ~w_pending_d;
            r_digit_en   <= w_digit_en_d;
            r_frame_done <= w_frame_done_d;
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.sel        = r_sel;
    assign bus.disp_value = r_disp;
    assign bus.digit_en   = r_digit_en;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a timing model derived from the cycle count
// since reset plus a queue of accepted loads, checked every cycle by a separate monitor.
module tb_seven_seg_scan_ctrl;
    import seven_seg_pkg::*;

    localparam int unsigned CLK_DIV      = 4;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int          DIGIT_P      = CLK_DIV + BLANK_CYCLES;
    localparam int          FRAME_P      = 8 * DIGIT_P;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scan_ctrl_if bus ();

    seven_seg_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc_n    = -1;
    bit          running  = 1'b1;
    logic [31:0] exp_disp = '0;
    logic [31:0] load_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    endtask

    // Model: cycle index since reset and the one-deep buffer as a queue of accepted values.
    always @(posedge clk) begin
        if (rst) begin
            cyc_n    = 0;
            exp_disp = '0;
            load_q.delete();
        end else if (cyc_n >= 0) begin
            if (bus.load_valid && load_q.size() == 0) load_q.push_back(bus.load_data);
            cyc_n++;
        end
    end

    // Monitor: digit k is lit in slot k of each 6-cycle digit period; cycle 0 sits in the
    // BLANK tail of digit 0, so the slot position is offset by CLK_DIV.
    always @(negedge clk) begin
        int          m;
        int          sh;
        logic [2:0]  es;
        logic        lit;
        logic        efd;
        logic [7:0]  een;
        if (running && cyc_n >= 0) begin
            m   = cyc_n + CLK_DIV;
            es  = 3'((m / DIGIT_P) % 8);
            lit = (m % DIGIT_P) < CLK_DIV;
            efd = (m % FRAME_P) == 0;
            if (efd && load_q.size() != 0) exp_disp = load_q.pop_front();
            een = 8'hFF;
            if (lit) begin
                een[es] = 1'b0;
`ifdef LEAD_ZERO_SUPPRESS_EN
                sh = 28 - 4 * int'(es);
                if (es != 3'd7 && (exp_disp >> sh) == 32'd0) een = 8'hFF;
`else
                sh = 0;
`endif
            end
            check("sel", 32'(bus.sel), 32'(es));
            check("digit_en", 32'(bus.digit_en), 32'(een));
            check("frame_done", 32'(bus.frame_done), 32'(efd));
            check("disp_value", bus.disp_value, exp_disp);
            check("load_ready", 32'(bus.load_ready), 32'(load_q.size() == 0));
        end
    end

    // Hold valid until the DUT takes the value (bounded).
    task automatic hold_load(input logic [31:0] val);
        int k;
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = val;
        k = 0;
        while (!bus.load_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL load_accept_timeout: load_ready stayed %b, expected 1", bus.load_ready);
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    // Leaves the caller on the negedge of the frame_done cycle.
    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.frame_done && k < 100);
        if (!bus.frame_done) begin
            n_checks++;
            $display("FAIL frame_done_timeout: frame_done=%b, expected 1 within 100 cycles",
                     bus.frame_done);
        end
    endtask

    task automatic wait_sel_show(input logic [2:0] s);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.sel == s && bus.digit_en != 8'hFF) && k < 100);
        if (!(bus.sel == s && bus.digit_en != 8'hFF)) begin
            n_checks++;
            $display("FAIL sel_show_timeout: sel=%0d digit_en=%h, expected sel %0d lit",
                     bus.sel, bus.digit_en, s);
        end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Scan from reset, then a single load while idle.
        repeat (10) @(negedge clk);
        hold_load(32'h1234ABCD);

        // Held while pending: accepted on the commit edge, commits one frame later.
        hold_load(32'hDEADBEEF);
        wait_frame();

        // Load offered on the boundary cycle itself.
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hC0FFEE00;
        @(negedge clk);
        bus.load_valid = 1'b0;
        wait_frame();

        // Reset mid-SHOW on digit 5 with a value pending; it must never reach disp_value.
        hold_load(32'h55AA55AA);
        wait_sel_show(3'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);

        // Leading-zero patterns.
        hold_load(32'h000000A5);
        wait_frame();
        wait_frame();
        hold_load(32'h00000000);
        wait_frame();
        wait_frame();
        hold_load(32'h00F00000);
        wait_frame();
        wait_frame();

        // Randomised offers, often with leading zeros.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                bus.load_valid = 1'b1;
                bus.load_data  = $urandom >> $urandom_range(0, 32);
            end else begin
                bus.load_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        repeat (2 * FRAME_P) @(negedge clk);

        running = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
